// File: rtl/memory_game_ctrl.sv
// Turn sequencer for the 4x4 card-matching game: per-card face-up/matched state,
// cursor, two-player scoring, mismatch reveal timing and the per-turn timeout.
module memory_game_ctrl #(
    parameter int N_CARDS     = 16,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int TURN_CYCLES = 375_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 btn_sel,
    input  logic [3*N_CARDS-1:0] symbols,
    output logic [3:0]           cursor,
    output logic [N_CARDS-1:0]   face_up,
    output logic [N_CARDS-1:0]   matched,
    output logic                 player,
    output logic [3:0]           score0,
    output logic [3:0]           score1,
    output logic [28:0]          turn_left,
    output logic                 game_over
);

    localparam int                 SHOW_W    = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [SHOW_W-1:0]  SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [28:0]        TURN_LOAD = 29'(TURN_CYCLES - 1);
    localparam logic [N_CARDS-1:0] ALL_ONES  = {N_CARDS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PICK1   = 3'd1,
        S_PICK2   = 3'd2,
        S_COMPARE = 3'd3,
        S_SHOW    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e              state_q;
    logic [3:0]          cursor_q;
    logic [3:0]          first_q;
    logic [3:0]          second_q;
    logic [N_CARDS-1:0]  face_up_q;
    logic [N_CARDS-1:0]  matched_q;
    logic                player_q;
    logic [3:0]          score0_q;
    logic [3:0]          score1_q;
    logic [28:0]         turn_q;
    logic [SHOW_W-1:0]   show_q;
    logic                game_over_q;

    logic                sel_valid_s;
    logic [3:0]          cursor_mv_s;
    logic                timer_zero_s;
    logic [28:0]         turn_dec_s;
    logic [N_CARDS-1:0]  pair_mask_s;
    logic                sym_eq_s;
    logic                all_matched_s;

    function automatic logic [N_CARDS-1:0] card_bit(input logic [3:0] idx);
        logic [N_CARDS-1:0] one;
        one = {{(N_CARDS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    function automatic logic [2:0] sym_of(input logic [3*N_CARDS-1:0] syms, input logic [3:0] idx);
        logic [5:0] base;
        base = {2'b00, idx} * 6'd3;
        return syms[base +: 3];
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'd8) ? 4'd8 : s + 4'd1;
    endfunction

    // Decode of the current-cycle select, cursor move, timer step and pair comparison.
    always_comb begin
        sel_valid_s   = btn_sel && !face_up_q[cursor_q] && !matched_q[cursor_q];
        if (btn_next && !btn_prev) begin
            cursor_mv_s = cursor_q + 4'd1;
        end else if (btn_prev && !btn_next) begin
            cursor_mv_s = cursor_q - 4'd1;
        end else begin
            cursor_mv_s = cursor_q;
        end
        timer_zero_s  = (turn_q == 29'd0);
        // Holds at zero so a select that wins against expiry leaves no wrapped timer.
        turn_dec_s    = timer_zero_s ? 29'd0 : turn_q - 29'd1;
        pair_mask_s   = card_bit(first_q) | card_bit(second_q);
        sym_eq_s      = (sym_of(symbols, first_q) == sym_of(symbols, second_q));
        all_matched_s = ((matched_q | pair_mask_s) == ALL_ONES);
    end

    // Turn FSM with all game state and outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cursor_q    <= 4'd0;
            first_q     <= 4'd0;
            second_q    <= 4'd0;
            face_up_q   <= {N_CARDS{1'b0}};
            matched_q   <= {N_CARDS{1'b0}};
            player_q    <= 1'b0;
            score0_q    <= 4'd0;
            score1_q    <= 4'd0;
            turn_q      <= 29'd0;
            show_q      <= {SHOW_W{1'b0}};
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        face_up_q   <= {N_CARDS{1'b0}};
                        matched_q   <= {N_CARDS{1'b0}};
                        score0_q    <= 4'd0;
                        score1_q    <= 4'd0;
                        cursor_q    <= 4'd0;
                        player_q    <= 1'b0;
                        turn_q      <= TURN_LOAD;
                        game_over_q <= 1'b0;
                        state_q     <= S_PICK1;
                    end
                end
                S_PICK1: begin
                    cursor_q <= cursor_mv_s;
                    if (sel_valid_s) begin
                        face_up_q <= face_up_q | card_bit(cursor_q);
                        first_q   <= cursor_q;
                        turn_q    <= turn_dec_s;
                        state_q   <= S_PICK2;
                    end else if (timer_zero_s) begin
                        player_q <= ~player_q;
                        turn_q   <= TURN_LOAD;
                    end else begin
                        turn_q <= turn_dec_s;
                    end
                end
                S_PICK2: begin
                    cursor_q <= cursor_mv_s;
                    if (sel_valid_s) begin
                        face_up_q <= face_up_q | card_bit(cursor_q);
                        second_q  <= cursor_q;
                        turn_q    <= turn_dec_s;
                        state_q   <= S_COMPARE;
                    end else if (timer_zero_s) begin
                        face_up_q <= face_up_q & ~card_bit(first_q);
                        player_q  <= ~player_q;
                        turn_q    <= TURN_LOAD;
                        state_q   <= S_PICK1;
                    end else begin
                        turn_q <= turn_dec_s;
                    end
                end
                S_COMPARE: begin
                    if (sym_eq_s) begin
                        matched_q <= matched_q | pair_mask_s;
                        face_up_q <= face_up_q & ~pair_mask_s;
                        if (player_q) begin
                            score1_q <= sat_inc(score1_q);
                        end else begin
                            score0_q <= sat_inc(score0_q);
                        end
                        turn_q      <= TURN_LOAD;
                        game_over_q <= all_matched_s;
                        state_q     <= all_matched_s ? S_DONE : S_PICK1;
                    end else begin
                        show_q  <= SHOW_LOAD;
                        state_q <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (show_q == {SHOW_W{1'b0}}) begin
                        face_up_q <= face_up_q & ~pair_mask_s;
                        player_q  <= ~player_q;
                        turn_q    <= TURN_LOAD;
                        state_q   <= S_PICK1;
                    end else begin
                        show_q <= show_q - {{(SHOW_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cursor    = cursor_q;
    assign face_up   = face_up_q;
    assign matched   = matched_q;
    assign player    = player_q;
    assign score0    = score0_q;
    assign score1    = score1_q;
    assign turn_left = turn_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed self-checking bench for memory_game_ctrl with short reveal/turn timers.
module tb_memory_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        btn_sel = 1'b0;
    logic [47:0] symbols;
    logic [3:0]  cursor;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic [28:0] turn_left;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;

    always #5 clk = ~clk;

    memory_game_ctrl #(
        .N_CARDS    (16),
        .SHOW_CYCLES(4),
        .TURN_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .btn_sel  (btn_sel),
        .symbols  (symbols),
        .cursor   (cursor),
        .face_up  (face_up),
        .matched  (matched),
        .player   (player),
        .score0   (score0),
        .score1   (score1),
        .turn_left(turn_left),
        .game_over(game_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel();
        btn_sel = 1'b1;
        tick();
        btn_sel = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_next();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        cur = (cur + 1) % 16;
    endtask

    task automatic pulse_prev();
        btn_prev = 1'b1;
        tick();
        btn_prev = 1'b0;
        cur = (cur + 15) % 16;
    endtask

    task automatic goto_card(input int a);
        int d;
        d = (a - cur) & 15;
        if (d <= 8) begin
            repeat (d) pulse_next();
        end else begin
            repeat (16 - d) pulse_prev();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cursor"}, 32'(cursor), 32'h0);
        check({tag, "_face"}, 32'(face_up), 32'h0);
        check({tag, "_matched"}, 32'(matched), 32'h0);
        check({tag, "_player"}, 32'(player), 32'h0);
        check({tag, "_scores"}, 32'({score1, score0}), 32'h0);
        check({tag, "_turn"}, 32'(turn_left), 32'h0);
        check({tag, "_over"}, 32'(game_over), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            symbols[3*i +: 3] = 3'(i / 2);
        end

        // Reset
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Start
        pulse_start();
        check("start_turn", 32'(turn_left), 32'd19);
        check("start_player", 32'(player), 32'd0);
        check("start_over", 32'(game_over), 32'd0);

        // Match cards 0 and 1
        pulse_sel();
        check("pick1_face", 32'(face_up), 32'h0001);
        pulse_next();
        check("next_cursor", 32'(cursor), 32'd1);
        pulse_sel();
        check("pick2_face", 32'(face_up), 32'h0003);
        tick();
        check("match_matched", 32'(matched), 32'h0003);
        check("match_score0", 32'(score0), 32'd1);
        check("match_face", 32'(face_up), 32'h0000);
        check("match_player", 32'(player), 32'd0);
        check("match_turn", 32'(turn_left), 32'd19);

        // Mismatch cards 2 and 4
        pulse_next();
        pulse_sel();
        pulse_next();
        pulse_next();
        pulse_sel();
        for (int i = 0; i < 5; i++) begin
            check("show_face", 32'(face_up), 32'h0014);
            btn_next = (i == 1);
            tick();
            btn_next = 1'b0;
        end
        check("show_cursor_frozen", 32'(cursor), 32'd4);
        check("show_face_clr", 32'(face_up), 32'h0000);
        check("show_player", 32'(player), 32'd1);
        check("show_turn", 32'(turn_left), 32'd19);

        // Invalid select, wrap, simultaneous buttons
        goto_card(0);
        pulse_sel();
        check("inv_sel_face", 32'(face_up), 32'h0000);
        check("inv_sel_matched", 32'(matched), 32'h0003);
        pulse_prev();
        check("wrap_prev", 32'(cursor), 32'd15);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        check("both_btn", 32'(cursor), 32'd15);
        check("both_turn", 32'(turn_left), 32'd12);

        // PICK1 timeout: timer 12 -> 7 after moves, expires 8 ticks later
        goto_card(4);
        repeat (8) tick();
        check("t1_player", 32'(player), 32'd0);
        check("t1_turn", 32'(turn_left), 32'd19);

        // PICK2 timeout
        pulse_sel();
        check("t2_face", 32'(face_up), 32'h0010);
        repeat (18) tick();
        check("t2_turn0", 32'(turn_left), 32'd0);
        check("t2_face_hold", 32'(face_up), 32'h0010);
        tick();
        check("t2_face_clr", 32'(face_up), 32'h0000);
        check("t2_player", 32'(player), 32'd1);
        check("t2_turn", 32'(turn_left), 32'd19);
        pulse_sel();
        pulse_next();
        pulse_sel();
        tick();
        check("t2_pick1_matched", 32'(matched), 32'h0033);
        check("t2_score1", 32'(score1), 32'd1);

        // Select on the cycle the timer reads 0 is accepted
        pulse_next();
        pulse_sel();
        pulse_next();
        repeat (16) tick();
        check("z_turn0", 32'(turn_left), 32'd0);
        pulse_sel();
        check("z_face", 32'(face_up), 32'h00C0);
        tick();
        check("z_matched", 32'(matched), 32'h00F3);
        check("z_score1", 32'(score1), 32'd2);
        check("z_player", 32'(player), 32'd1);

        // Finish the game: pairs 1, 4, 5, 6, 7
        for (int p = 0; p < 5; p++) begin
            int a;
            a = (p == 0) ? 2 : 2 * (p + 3);
            if (p == 4) begin
                check("pre_done_over", 32'(game_over), 32'd0);
            end
            goto_card(a);
            pulse_sel();
            pulse_next();
            pulse_sel();
            tick();
        end
        check("done_over", 32'(game_over), 32'd1);
        check("done_matched", 32'(matched), 32'hFFFF);
        check("done_score0", 32'(score0), 32'd1);
        check("done_score1", 32'(score1), 32'd7);
        tick();
        check("done_hold", 32'(game_over), 32'd1);

        // New game from DONE
        pulse_start();
        cur = 0;
        check("restart_over", 32'(game_over), 32'd0);
        check("restart_matched", 32'(matched), 32'h0000);
        check("restart_scores", 32'({score1, score0}), 32'h0);
        check("restart_turn", 32'(turn_left), 32'd19);

        // start outside IDLE/DONE is ignored
        pulse_sel();
        pulse_start();
        check("ign_start_face", 32'(face_up), 32'h0001);
        check("ign_start_turn", 32'(turn_left), 32'd17);

        // Mismatch 0/2, then async reset mid-SHOW
        goto_card(2);
        pulse_sel();
        tick();
        tick();
        check("pre_rst_face", 32'(face_up), 32'h0005);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_turn", 32'(turn_left), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
